serial_frame_ctrl: RTL and testbench
====================================

# serial_frame_ctrl

Sequencing controller for the serial-in/parallel-out shift datapath. Detects a start bit on a serial line, enables the shift register for exactly WIDTH data bits, checks optional even parity and the stop bit, and presents the captured word on a valid/ready output port. It sits between a raw serial input pin and any parallel consumer.

## Interface
- WIDTH, 4, number of data bits per frame (2..16)
- PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- SerialIn  input  1  serial line, idle high, one bit per clk
- DataReady  input  1  consumer accepts DataOut this cycle when DataValid=1
- DataOut  output  WIDTH  captured word, first received bit in bit 0
- DataValid  output  1  DataOut holds an unconsumed word
- ShiftEn  output  1  shift-register enable, high exactly during the WIDTH data-bit cycles
- Busy  output  1  high whenever the FSM is not in IDLE
- ParityErr  output  1  one-cycle pulse: frame discarded, parity mismatch
- FrameErr  output  1  one-cycle pulse: frame discarded, stop bit sampled 0
- Overrun  output  1  one-cycle pulse: good frame dropped, holding register still full

## Operation
- Reset (rst_n=0, asynchronous): FSM to IDLE, bit counter 0, shift register 0, DataOut=0, all outputs 0.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: SerialIn=0 sampled on an edge -> DATA, counter cleared. SerialIn=1 -> stay.
- DATA: ShiftEn=1. Each edge shifts SerialIn in (LSB first) and increments the counter. After the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
- PARITY: sample SerialIn as the parity bit. XOR of data bits and parity bit must be 0. Record the result -> STOP.
- STOP: sample SerialIn -> IDLE unconditionally.
  - Stop bit 0: FrameErr pulses.
  - Parity failed: ParityErr pulses. Both errors may pulse together.
  - No error: frame is good.
- Good frame when DataValid=0, or DataValid=1 with DataReady=1 in the same cycle: load DataOut; DataValid=1 next cycle.
- Good frame when DataValid=1 and DataReady=0: Overrun pulses; DataOut and DataValid are unchanged; the new word is dropped.
- DataValid=1 and DataReady=1 with no frame completing: DataValid=0 next cycle. DataOut keeps its last value.
- Errored frames never touch DataOut or DataValid.
- No bit errors are detected mid-frame. Only the parity and stop bits are checked.

## Timing
- Start bit sampled at edge t.
- Data bits sampled at edges t+1 .. t+WIDTH. ShiftEn is high in the cycles ending at those edges.
- Parity bit sampled at edge t+WIDTH+1 (PARITY_EN=1).
- Stop bit sampled at edge S = t+WIDTH+2. With PARITY_EN=0, S = t+WIDTH+1.
- DataValid rises, or the error/Overrun pulse appears, in the cycle after edge S. Pulses last exactly one cycle.
- Back-to-back frames: a start bit may be sampled at edge S+1, so there are zero idle cycles between frames.
- Busy is high from the cycle after edge t through the cycle ending at edge S.
- Reset asserted mid-frame aborts the frame with no pulses. The FSM and all outputs return to their reset values immediately.
- A stop bit of 0 does not re-arm as a start bit. The FSM still returns to IDLE and samples afresh at edge S+1.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - the counter-width constant $clog2(WIDTH+1).
- One sub-module, sipo_shift: a WIDTH-bit serial-in/parallel-out register with ports clk, rst_n, ShiftEn, ShiftIn, ParallelOut, ShiftOut.
- The controller drives ShiftEn and taps ParallelOut. It owns the FSM, the counter, the parity accumulator and the output holding register.

## Test plan
All scenarios use WIDTH=4 and PARITY_EN=1 unless noted.
- Good frame: SerialIn 0,1,1,0,1,1,1 from edge t (start, data 1,1,0,1, parity 1, stop 1).
  - Required: ShiftEn high for 4 cycles.
  - Required: DataOut=4'b1011 and DataValid=1 after edge t+6, held while DataReady=0.
  - Required: DataReady=1 clears DataValid next cycle.
- Parity error: same frame with parity bit 0.
  - Required: ParityErr pulses one cycle after the stop edge; DataValid stays 0; DataOut unchanged.
- Framing error: good frame but stop bit 0.
  - Required: FrameErr pulse; no DataValid; FSM in IDLE; a start bit at the next edge is accepted.
- Overrun, then simultaneous accept:
  - Frame 4'b0011 completes with DataReady=0, then frame 4'b1100 completes with DataReady still 0. Required: Overrun pulse; DataOut stays 4'b0011.
  - Repeat with DataReady=1 in the completion cycle. Required: DataOut=4'b1100; DataValid stays 1.
- Reset mid-frame: rst_n low after the second data bit.
  - Required: all outputs 0 immediately.
  - Required: the next clean frame 4'b0110 is received correctly.
- PARITY_EN=0 back-to-back: two frames 4'b1001 and 4'b0101 with zero idle cycles, DataReady tied 1.
  - Required: each DataValid appears one cycle after its stop edge (t+5) with the correct word.
  - Required: Overrun never pulses.

Source files
------------

// File: rtl/serial_frame_ctrl_pkg.sv
// Shared state encoding and sizing helper for the serial frame controller.
package serial_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } frameState_e;

    // Bit counter must hold 0..width.
    function automatic int unsigned cntWidth(int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out register; bits enter at the MSB so the first bit ends up in bit 0.
module sipo_shift #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ShiftEn,
    input  logic             ShiftIn,
    output logic [WIDTH-1:0] ParallelOut,
    output logic             ShiftOut
);

    logic [WIDTH-1:0] regQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regQ <= '0;
        end else if (ShiftEn) begin
            regQ <= {ShiftIn, regQ[WIDTH-1:1]};
        end
    end

    assign ParallelOut = regQ;
    assign ShiftOut    = regQ[0];

endmodule

// File: rtl/serial_frame_ctrl.sv
// Start-bit detection, data/parity/stop sequencing and a one-word valid/ready holding register.
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SerialIn,
    input  logic             DataReady,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    output logic             ShiftEn,
    output logic             Busy,
    output logic             ParityErr,
    output logic             FrameErr,
    output logic             Overrun
);

    localparam int unsigned      CntW    = cntWidth(WIDTH);
    localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);

    frameState_e      stateQ;
    logic [CntW-1:0]  cntQ;
    logic             shiftEnQ;
    logic             busyQ;
    logic             parAccQ;
    logic             parFailQ;
    logic [WIDTH-1:0] dataOutQ;
    logic             dataValidQ;
    logic             parityErrQ;
    logic             frameErrQ;
    logic             overrunQ;
    logic [WIDTH-1:0] parallelOut;
    logic             shiftOut;

    sipo_shift #(
        .WIDTH(WIDTH)
    ) uShift (
        .clk        (clk),
        .rst_n      (rst_n),
        .ShiftEn    (shiftEnQ),
        .ShiftIn    (SerialIn),
        .ParallelOut(parallelOut),
        .ShiftOut   (shiftOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            cntQ       <= '0;
            shiftEnQ   <= 1'b0;
            busyQ      <= 1'b0;
            parAccQ    <= 1'b0;
            parFailQ   <= 1'b0;
            dataOutQ   <= '0;
            dataValidQ <= 1'b0;
            parityErrQ <= 1'b0;
            frameErrQ  <= 1'b0;
            overrunQ   <= 1'b0;
        end else begin
            parityErrQ <= 1'b0;
            frameErrQ  <= 1'b0;
            overrunQ   <= 1'b0;
            if (dataValidQ && DataReady) begin
                dataValidQ <= 1'b0;
            end
            // Tracks the parity of the whole register: add the bit entering, cancel the bit leaving.
            if (shiftEnQ) begin
                parAccQ <= parAccQ ^ SerialIn ^ shiftOut;
            end
            unique case (stateQ)
                StIdle: begin
                    if (!SerialIn) begin
                        stateQ   <= StData;
                        cntQ     <= '0;
                        shiftEnQ <= 1'b1;
                        busyQ    <= 1'b1;
                        parFailQ <= 1'b0;
                    end
                end
                StData: begin
                    cntQ <= cntQ + CntW'(1);
                    if (cntQ == LastBit) begin
                        shiftEnQ <= 1'b0;
                        stateQ   <= (PARITY_EN != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    parFailQ <= parAccQ ^ SerialIn;
                    stateQ   <= StStop;
                end
                StStop: begin
                    stateQ     <= StIdle;
                    busyQ      <= 1'b0;
                    frameErrQ  <= !SerialIn;
                    parityErrQ <= parFailQ;
                    if (SerialIn && !parFailQ) begin
                        if (!dataValidQ || DataReady) begin
                            dataOutQ   <= parallelOut;
                            dataValidQ <= 1'b1;
                        end else begin
                            overrunQ <= 1'b1;
                        end
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign DataOut   = dataOutQ;
    assign DataValid = dataValidQ;
    assign ShiftEn   = shiftEnQ;
    assign Busy      = busyQ;
    assign ParityErr = parityErrQ;
    assign FrameErr  = frameErrQ;
    assign Overrun   = overrunQ;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor pops and compares.
module tb_serial_frame_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] ev;   // {valid, data[3:0], parityErr, frameErr, overrun}
    } expItem_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sInA, readyA, sInB, readyB;
    logic [3:0] doutA, doutB;
    logic       validA, shiftEnA, busyA, perrA, ferrA, ovrA;
    logic       validB, shiftEnB, busyB, perrB, ferrB, ovrB;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         seCntA = 0;
    int         seCntB = 0;
    int         ovrCntB = 0;
    expItem_t   qA[$];
    expItem_t   qB[$];
    logic       prevVA = 1'b0, prevVB = 1'b0;
    logic [3:0] prevOutA = '0, prevOutB = '0;
    logic [7:0] obs;
    expItem_t   e;

    serial_frame_ctrl #(.WIDTH(4), .PARITY_EN(1)) dutA (
        .clk(clk), .rst_n(rst_n), .SerialIn(sInA), .DataReady(readyA),
        .DataOut(doutA), .DataValid(validA), .ShiftEn(shiftEnA), .Busy(busyA),
        .ParityErr(perrA), .FrameErr(ferrA), .Overrun(ovrA)
    );

    serial_frame_ctrl #(.WIDTH(4), .PARITY_EN(0)) dutB (
        .clk(clk), .rst_n(rst_n), .SerialIn(sInB), .DataReady(readyB),
        .DataOut(doutB), .DataValid(validB), .ShiftEn(shiftEnB), .Busy(busyB),
        .ParityErr(perrB), .FrameErr(ferrB), .Overrun(ovrB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shiftEnA === 1'b1) seCntA++;
        if (shiftEnB === 1'b1) seCntB++;
        if (ovrB === 1'b1) ovrCntB++;
    end

    // Monitor: an event is any pulse, a rising DataValid, or a new word loaded while valid.
    always @(negedge clk) begin
        obs = {validA, doutA, perrA, ferrA, ovrA};
        if (perrA || ferrA || ovrA || (validA && (!prevVA || doutA != prevOutA))) begin
            checks++;
            if (qA.size() == 0) begin
                errors++;
                $display("FAIL dutA unexpected event: cyc=%0d got %b", cyc, obs);
            end else begin
                e = qA.pop_front();
                if (e.cyc != cyc || e.ev !== obs) begin
                    errors++;
                    $display("FAIL dutA event: got cyc=%0d %b, need cyc=%0d %b",
                             cyc, obs, e.cyc, e.ev);
                end
            end
        end
        prevVA   = validA;
        prevOutA = doutA;

        obs = {validB, doutB, perrB, ferrB, ovrB};
        if (perrB || ferrB || ovrB || (validB && (!prevVB || doutB != prevOutB))) begin
            checks++;
            if (qB.size() == 0) begin
                errors++;
                $display("FAIL dutB unexpected event: cyc=%0d got %b", cyc, obs);
            end else begin
                e = qB.pop_front();
                if (e.cyc != cyc || e.ev !== obs) begin
                    errors++;
                    $display("FAIL dutB event: got cyc=%0d %b, need cyc=%0d %b",
                             cyc, obs, e.cyc, e.ev);
                end
            end
        end
        prevVB   = validB;
        prevOutB = doutB;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic b);
        if (which) sInB = b;
        else sInA = b;
    endtask

    task automatic pushExp(input bit which, input int c, input logic v, input logic [3:0] d,
                           input logic pe, input logic fe, input logic ov);
        expItem_t it;
        it.cyc = c;
        it.ev  = {v, d, pe, fe, ov};
        if (which) qB.push_back(it);
        else qA.push_back(it);
    endtask

    // Sends start, 4 data bits LSB first, parity (dutA only) and stop; returns the start edge.
    task automatic sendFrame(input bit which, input logic [3:0] d, input logic par,
                             input logic stop, input logic readyAtStop, output int tStart);
        int se0;
        se0 = which ? seCntB : seCntA;
        drive(which, 1'b0);
        tick();
        tStart = cyc;
        check("busy after start", which ? busyB : busyA, 1);
        for (int i = 0; i < 4; i++) begin
            drive(which, d[i]);
            tick();
        end
        if (!which) begin
            drive(which, par);
            tick();
        end
        drive(which, stop);
        if (readyAtStop) readyA = 1'b1;
        tick();
        if (readyAtStop) readyA = 1'b0;
        drive(which, 1'b1);
        check("shiftEn cycles", (which ? seCntB : seCntA) - se0, 4);
        check("busy after stop", which ? busyB : busyA, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        sInA = 1'b1; sInB = 1'b1; readyA = 1'b0; readyB = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset DataOut", doutA, 0);
        check("reset DataValid", validA, 0);
        check("reset ShiftEn", shiftEnA, 0);
        check("reset Busy", busyA, 0);
        check("reset pulses", {perrA, ferrA, ovrA}, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Good frame 1,1,0,1 parity 1 -> 4'b1011, held until accepted.
        sendFrame(0, 4'b1011, 1'b1, 1'b1, 1'b0, t);
        pushExp(0, t + 6, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("held valid", validA, 1);
        check("held data", doutA, 4'b1011);
        readyA = 1'b1;
        tick();
        readyA = 1'b0;
        check("valid cleared by ready", validA, 0);
        check("data kept after accept", doutA, 4'b1011);

        // Parity error: same data, parity bit 0.
        sendFrame(0, 4'b1011, 1'b0, 1'b1, 1'b0, t);
        pushExp(0, t + 6, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0);
        tick();
        check("parity pulse one cycle", perrA, 0);
        check("parity no valid", validA, 0);

        // Framing error then a start bit on the very next edge.
        sendFrame(0, 4'b0110, 1'b0, 1'b0, 1'b0, t);
        pushExp(0, t + 6, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0);
        sendFrame(0, 4'b0011, 1'b0, 1'b1, 1'b0, t);
        pushExp(0, t + 6, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);

        // Overrun with DataReady low, then simultaneous accept at completion.
        sendFrame(0, 4'b1100, 1'b0, 1'b1, 1'b0, t);
        pushExp(0, t + 6, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);
        check("overrun keeps data", doutA, 4'b0011);
        sendFrame(0, 4'b1100, 1'b0, 1'b1, 1'b1, t);
        pushExp(0, t + 6, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
        tick();
        check("accept+load valid", validA, 1);
        check("accept+load data", doutA, 4'b1100);
        check("accept+load no overrun", ovrA, 0);
        readyA = 1'b1;
        tick();
        readyA = 1'b0;

        // Reset after the second data bit.
        drive(0, 1'b0); tick();
        drive(0, 1'b0); tick();
        drive(0, 1'b1); tick();
        rst_n = 1'b0;
        #1;
        check("mid reset ShiftEn", shiftEnA, 0);
        check("mid reset Busy", busyA, 0);
        check("mid reset DataOut", doutA, 0);
        check("mid reset valid/pulses", {validA, perrA, ferrA, ovrA}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        sendFrame(0, 4'b0110, 1'b0, 1'b1, 1'b0, t);
        pushExp(0, t + 6, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);

        // No-parity instance, back-to-back frames, DataReady tied high.
        sendFrame(1, 4'b1001, 1'b0, 1'b1, 1'b0, t);
        pushExp(1, t + 5, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
        sendFrame(1, 4'b0101, 1'b0, 1'b1, 1'b0, t);
        pushExp(1, t + 5, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);

        repeat (4) tick();
        check("dutA events drained", qA.size(), 0);
        check("dutB events drained", qB.size(), 0);
        check("dutB never overran", ovrCntB, 0);
        check("dutB valid consumed", validB, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
